// File: rtl/uart_pkg.sv
// Shared definitions for the inter-board move link UART.
// Covers the default timing, the receiver state set and the 2-of-3 vote.
package uart_pkg;

    localparam int unsigned DEF_CLK_HZ        = 65_000_000;
    localparam int unsigned DEF_BAUD_RATE     = 9600;
    localparam int unsigned DEF_SAMP_PER_BIT  = 16;
    localparam int unsigned DEF_CLK_PER_SAMP  = 423;
    localparam int unsigned DEF_PKT_LEN       = 8;
    localparam int unsigned DEF_WAITING_COUNT = 65_000;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        RECOVER = 3'd4
    } rx_state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_samp_tick.sv
// Oversample tick divider: emits one tick every CLK_PER_SAMP clocks.
// A synchronous clear re-phases the divider to the current cycle.
module uart_samp_tick
    import uart_pkg::*;
#(
    parameter int unsigned CLK_PER_SAMP = DEF_CLK_PER_SAMP
) (
    input  logic clk_in,
    input  logic rst_in_n,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = $clog2(CLK_PER_SAMP);
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_PER_SAMP - 1);

    logic [CW-1:0] div_cnt;

    // First tick lands CLK_PER_SAMP clocks after a clear.
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else if (clr) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            tick    <= 1'b1;
        end else begin
            div_cnt <= div_cnt + CW'(1);
            tick    <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_move_rx.sv
// Receive end of the inter-board move link: 8N1 deserialiser with 16x
// oversampling, majority vote, framing check and idle-line recovery.
module uart_move_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ        = DEF_CLK_HZ,
    parameter int unsigned BAUD_RATE     = DEF_BAUD_RATE,
    parameter int unsigned SAMP_PER_BIT  = DEF_SAMP_PER_BIT,
    parameter int unsigned CLK_PER_SAMP  = DEF_CLK_PER_SAMP,
    parameter int unsigned PKT_LEN       = DEF_PKT_LEN,
    parameter int unsigned WAITING_COUNT = DEF_WAITING_COUNT
) (
    input  logic               clk_in,
    input  logic               rst_in_n,
    input  logic               rx,
    output logic [PKT_LEN-1:0] data_out,
    output logic               ready,
    output logic               frame_err,
    output logic               busy
);

    if (SAMP_PER_BIT < 8 || PKT_LEN < 2 || CLK_PER_SAMP < 2 ||
        WAITING_COUNT < 2 || CLK_HZ < BAUD_RATE) begin : g_bad_params
        $error("uart_move_rx: unsupported parameter set");
    end

    localparam int unsigned SC_W = $clog2(SAMP_PER_BIT);
    localparam int unsigned BI_W = $clog2(PKT_LEN);
    localparam int unsigned IC_W = $clog2(WAITING_COUNT);

    localparam logic [SC_W-1:0] SAMP_LAST = SC_W'(SAMP_PER_BIT - 1);
    localparam logic [SC_W-1:0] SAMP_V0   = SC_W'(SAMP_PER_BIT / 2 - 1);
    localparam logic [SC_W-1:0] SAMP_V1   = SC_W'(SAMP_PER_BIT / 2);
    localparam logic [SC_W-1:0] SAMP_V2   = SC_W'(SAMP_PER_BIT / 2 + 1);
    localparam logic [BI_W-1:0] BIT_LAST  = BI_W'(PKT_LEN - 1);
    localparam logic [IC_W-1:0] IDLE_LAST = IC_W'(WAITING_COUNT - 1);

    logic       rx_meta, rxs, rxs_prev;
    logic [1:0] sync_fill;
    logic       fall_c;

    rx_state_t          state_q, state_d;
    logic [SC_W-1:0]    samp_cnt_q, samp_cnt_d;
    logic [BI_W-1:0]    bit_idx_q, bit_idx_d;
    logic [2:0]         votes_q, votes_d;
    logic [PKT_LEN-1:0] shift_q, shift_d;
    logic [IC_W-1:0]    idle_cnt_q, idle_cnt_d;
    logic [PKT_LEN-1:0] data_d;
    logic               ready_d, frame_err_d, busy_d;
    logic               tick, tick_clr_c, bit_vote_c, stop_vote_c;

    // rxs_prev only carries real line history once both sync flops hold rx,
    // so a line that is low at reset release cannot fake a falling edge.
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            rx_meta   <= 1'b1;
            rxs       <= 1'b1;
            rxs_prev  <= 1'b0;
            sync_fill <= 2'd0;
        end else begin
            rx_meta   <= rx;
            rxs       <= rx_meta;
            rxs_prev  <= (sync_fill == 2'd2) ? rxs : 1'b0;
            if (sync_fill != 2'd2) begin
                sync_fill <= sync_fill + 2'd1;
            end
        end
    end

    assign fall_c = rxs_prev & ~rxs;

    uart_samp_tick #(
        .CLK_PER_SAMP (CLK_PER_SAMP)
    ) u_samp_tick (
        .clk_in   (clk_in),
        .rst_in_n (rst_in_n),
        .clr      (tick_clr_c),
        .tick     (tick)
    );

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            state_q    <= IDLE;
            samp_cnt_q <= '0;
            bit_idx_q  <= '0;
            votes_q    <= '0;
            shift_q    <= '0;
            idle_cnt_q <= '0;
            data_out   <= '0;
            ready      <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            samp_cnt_q <= samp_cnt_d;
            bit_idx_q  <= bit_idx_d;
            votes_q    <= votes_d;
            shift_q    <= shift_d;
            idle_cnt_q <= idle_cnt_d;
            data_out   <= data_d;
            ready      <= ready_d;
            frame_err  <= frame_err_d;
            busy       <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        samp_cnt_d  = samp_cnt_q;
        bit_idx_d   = bit_idx_q;
        votes_d     = votes_q;
        shift_d     = shift_q;
        idle_cnt_d  = idle_cnt_q;
        data_d      = data_out;
        ready_d     = 1'b0;
        frame_err_d = 1'b0;
        tick_clr_c  = 1'b0;
        bit_vote_c  = majority3(votes_q[0], votes_q[1], votes_q[2]);
        stop_vote_c = majority3(votes_q[0], votes_q[1], rxs);

        // Sample counting and vote capture are common to every framed state.
        if (tick && (state_q inside {START, DATA, STOP})) begin
            samp_cnt_d = (samp_cnt_q == SAMP_LAST) ? '0 : samp_cnt_q + SC_W'(1);
            if (samp_cnt_q == SAMP_V0) votes_d[0] = rxs;
            if (samp_cnt_q == SAMP_V1) votes_d[1] = rxs;
            if (samp_cnt_q == SAMP_V2) votes_d[2] = rxs;
        end

        case (state_q)
            IDLE: begin
                if (fall_c) begin
                    state_d    = START;
                    samp_cnt_d = '0;
                    tick_clr_c = 1'b1;
                end
            end
            START: begin
                if (tick && samp_cnt_q == SAMP_LAST) begin
                    state_d   = bit_vote_c ? IDLE : DATA;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (tick && samp_cnt_q == SAMP_LAST) begin
                    shift_d = {bit_vote_c, shift_q[PKT_LEN-1:1]};
                    if (bit_idx_q == BIT_LAST) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + BI_W'(1);
                    end
                end
            end
            STOP: begin
                // Decide at mid-bit so a back-to-back start edge is not missed.
                if (tick && samp_cnt_q == SAMP_V2) begin
                    samp_cnt_d = '0;
                    if (stop_vote_c) begin
                        data_d  = shift_q;
                        ready_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        idle_cnt_d  = '0;
                        state_d     = RECOVER;
                    end
                end
            end
            RECOVER: begin
                if (!rxs) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == IDLE_LAST) begin
                    idle_cnt_d = '0;
                    state_d    = IDLE;
                end else begin
                    idle_cnt_d = idle_cnt_q + IC_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_uart_move_rx.sv
// Directed bench for uart_move_rx: expected-event queue plus last-good-byte
// model checked every cycle, and literal spot checks at each scenario.
module tb_uart_move_rx;

    localparam int unsigned CPS = 4;
    localparam int unsigned SPB = 16;
    localparam int unsigned WC  = 100;
    localparam int          BIT = CPS * SPB;

    logic       clk_in   = 1'b0;
    logic       rst_in_n = 1'b0;
    logic       rx       = 1'b1;
    logic [7:0] data_out;
    logic       ready, frame_err, busy;

    uart_move_rx #(
        .SAMP_PER_BIT  (SPB),
        .CLK_PER_SAMP  (CPS),
        .PKT_LEN       (8),
        .WAITING_COUNT (WC)
    ) dut (
        .clk_in    (clk_in),
        .rst_in_n  (rst_in_n),
        .rx        (rx),
        .data_out  (data_out),
        .ready     (ready),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk_in = ~clk_in;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         exp_q[$];          // expected events: byte value, or -1 for a framing error
    int         rdy_cyc[$];
    int         cyc = 0;
    logic [7:0] model_data = 8'h00;
    logic       prev_pulse = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle compare against the event queue and last-good-byte model.
    always @(negedge clk_in) begin : cmp
        int front;
        cyc++;
        if (!rst_in_n) begin
            chk("reset_outputs", int'({data_out, ready, frame_err, busy}), 0);
            model_data = 8'h00;
            prev_pulse = 1'b0;
        end else begin
            front = (exp_q.size() != 0) ? exp_q[0] : -2;
            chk("pulse_exclusive", int'(ready & frame_err), 0);
            chk("pulse_single_cycle", int'((ready | frame_err) & prev_pulse), 0);
            if (ready) begin
                chk("ready_event", int'(data_out), front);
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                if (front >= 0) model_data = 8'(front);
                rdy_cyc.push_back(cyc);
            end else if (frame_err) begin
                chk("frame_err_event", -1, front);
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            chk("data_hold", int'(data_out), int'(model_data));
            prev_pulse = ready | frame_err;
        end
    end

    task automatic cyc_n(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int spike_bit);
        rx = 1'b0;
        cyc_n(BIT);
        for (int i = 0; i < 8; i++) begin
            if (i == spike_bit) begin
                rx = d[i];
                cyc_n(30);
                rx = ~d[i];
                cyc_n(CPS);
                rx = d[i];
                cyc_n(BIT - 30 - CPS);
            end else begin
                rx = d[i];
                cyc_n(BIT);
            end
        end
        rx = stop;
        cyc_n(BIT);
        rx = 1'b1;
    endtask

    task automatic drain(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0) break;
            cyc_n(1);
        end
        chk(name, exp_q.size(), 0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int spacing;
        rst_in_n = 1'b0;
        rx       = 1'b1;
        cyc_n(3);
        chk("reset_data_out", int'(data_out), 0);
        chk("reset_ready", int'(ready), 0);
        chk("reset_frame_err", int'(frame_err), 0);
        chk("reset_busy", int'(busy), 0);
        rst_in_n = 1'b1;
        cyc_n(10);

        // Clean frame
        exp_q.push_back(8'hA5);
        fork
            send_frame(8'hA5, 1'b1, -1);
            begin
                cyc_n(100);
                chk("a5_busy_mid_frame", int'(busy), 1);
            end
        join
        drain("a5_drain", 200);
        chk("a5_data", int'(data_out), 8'hA5);
        cyc_n(10);
        chk("a5_busy_after", int'(busy), 0);

        // Back-to-back frames, no idle gap
        rdy_cyc.delete();
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'hFF);
        send_frame(8'h3C, 1'b1, -1);
        send_frame(8'hFF, 1'b1, -1);
        drain("b2b_drain", 200);
        chk("b2b_ready_count", rdy_cyc.size(), 2);
        spacing = (rdy_cyc.size() >= 2) ? rdy_cyc[1] - rdy_cyc[0] : -1;
        chk("b2b_spacing", spacing, 10 * BIT);
        chk("b2b_data", int'(data_out), 8'hFF);
        cyc_n(20);

        // Short glitch is rejected, following frame is fine
        rx = 1'b0;
        cyc_n(20);
        rx = 1'b1;
        cyc_n(150);
        chk("glitch_busy", int'(busy), 0);
        chk("glitch_data", int'(data_out), 8'hFF);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, -1);
        drain("x81_drain", 200);
        chk("x81_data", int'(data_out), 8'h81);
        cyc_n(20);

        // One-sample spike inside data bit 3 is outvoted
        exp_q.push_back(8'h00);
        send_frame(8'h00, 1'b1, 3);
        drain("spike_drain", 200);
        chk("spike_data", int'(data_out), 8'h00);
        cyc_n(20);

        // Framing error, ignored frame during recovery, then a good frame
        exp_q.push_back(-1);
        send_frame(8'h55, 1'b0, -1);
        drain("ferr_drain", 200);
        chk("ferr_data_kept", int'(data_out), 8'h00);
        chk("ferr_busy_recover", int'(busy), 1);
        cyc_n(50);
        send_frame(8'h12, 1'b1, -1);
        cyc_n(150);
        chk("recover_busy_done", int'(busy), 0);
        chk("recover_ignored_frame", exp_q.size() + rdy_cyc.size(), 4);
        exp_q.push_back(8'h12);
        send_frame(8'h12, 1'b1, -1);
        drain("x12_drain", 200);
        chk("x12_data", int'(data_out), 8'h12);
        cyc_n(20);

        // Reset in the middle of DATA, released with the line still low
        rx = 1'b0;
        cyc_n(BIT);
        rx = 1'b1; cyc_n(BIT);
        rx = 1'b1; cyc_n(BIT);
        rx = 1'b0; cyc_n(BIT);
        rx = 1'b0; cyc_n(20);
        rst_in_n = 1'b0;
        #1;
        chk("async_rst_data", int'(data_out), 0);
        chk("async_rst_busy", int'(busy), 0);
        cyc_n(3);
        rst_in_n = 1'b1;
        cyc_n(8);
        chk("rst_low_line_no_start", int'(busy), 0);
        rx = 1'b1;
        cyc_n(200);
        chk("rst_after_busy", int'(busy), 0);
        chk("rst_no_events", exp_q.size(), 0);
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1, -1);
        drain("x7e_drain", 200);
        chk("x7e_data", int'(data_out), 8'h7E);
        cyc_n(20);
        chk("final_busy", int'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
